program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer-side counterpart to the CPU's instruction-memory read port.
- Receives a WebAssembly bytecode image as a byte stream (valid/ready) and writes it into internal byte storage. Holds the CPU in reset until the image is complete.
- Once loaded, serves CPU fetches over the same addr/extra/data/error interface the CPU uses with genrom.
- Sits between the host or boot channel and cpu; replaces genrom in loadable systems.

Parameters:
- AW, 5, address MSB index; storage depth DEPTH = 2**(AW+1) bytes (64 by default).
- EXTRA, 4, width of the extra field; read data width is 2**EXTRA*8 bits (128 by default).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader accepts the byte this cycle.
- in_data  in  8  stream byte.
- in_last  in  1  marks the final byte of the image.
- reload  in  1  single-cycle request to restart loading.
- cpu_reset  out  1  active-high reset to cpu; 1 while not DONE.
- load_count  out  AW+2  bytes written in the current load.
- load_error  out  1  image overflowed storage.
- mem_addr  in  AW+1  CPU read byte address.
- mem_extra  in  EXTRA  number of extra bytes beyond mem_addr (total bytes = extra+1).
- lower_bound  in  AW+1  lowest legal address.
- upper_bound  in  AW+1  highest legal address.
- mem_data  out  2**EXTRA*8  read data.
- mem_error  out  1  read fault.

Behaviour:
- States: LOAD, DONE, ERROR.
- Reset (reset=0, asynchronous) values:
  - state=LOAD, write pointer=0, load_count=0, load_error=0.
  - cpu_reset=1, in_ready=0 during reset, mem_data=0, mem_error=1.
  - Storage contents are not cleared.
- LOAD:
  - in_ready=1. A byte is accepted when in_valid && in_ready.
  - On accept: store[ptr]=in_data; ptr and load_count increment.
  - Accept with in_last=1 -> DONE next cycle.
  - Accept at ptr=DEPTH-1 with in_last=0 -> ERROR. That byte is stored; load_error=1 next cycle.
  - A DEPTH-byte image with last on byte DEPTH-1 -> DONE, not ERROR.
  - in_valid=0 -> no change; no timeout.
- DONE:
  - in_ready=0; cpu_reset=0 registered, so it deasserts the cycle after the state enters DONE.
- ERROR:
  - in_ready=0, cpu_reset=1, load_error=1. Exit only via reload or reset.
- reload (any state):
  - Next state LOAD; ptr=0, load_count=0, load_error=0, cpu_reset=1.
  - reload coincident with an accepted byte: reload wins and the byte is discarded.
- Read port: registered, latency 1 cycle.
  - Sampled each clk edge: mem_addr, mem_extra, bounds.
  - Following cycle: mem_data lane i (bits 8i+7:8i) = store[mem_addr+i] for i<=mem_extra; lanes above mem_extra are 0. Little-endian: lane 0 is mem_addr.
  - Address sum is computed at AW+2 bits, with no wrap-around.
- mem_error=1, with mem_data forced to 0, when any of these holds:
  - state != DONE
  - mem_addr < lower_bound
  - mem_addr+mem_extra > upper_bound
  - mem_addr+mem_extra > DEPTH-1
- Write and read never coincide: reads are only valid in DONE, and writes only occur in LOAD.

Test Plan:
- Stream 6 bytes 41 03 0B 00 00 00 (last on 6th), bounds 0..63 -> in_ready=0 after 6th accept; load_count=6; cpu_reset falls one cycle after DONE; read addr=0 extra=1 -> mem_data=0x0341, mem_error=0.
- Drive reset low for 3 cycles mid-load (after 3 bytes) -> immediate cpu_reset=1, in_ready=0, load_count=0. After release, state is LOAD and a re-stream succeeds.
- Stream 64 bytes with last on byte 64 -> DONE, load_error=0. Stream 65 bytes without last -> ERROR after byte 64; load_error=1; cpu_reset stays 1; 65th byte is not accepted.
- After DONE, read addr=62 extra=1 -> data=store[62..63], error=0. Read addr=63 extra=1 -> error=1, data=0. Set lower_bound=8 and read addr=4 -> error=1.
- Read during LOAD at addr=0 -> mem_error=1. Pulse reload while DONE -> cpu_reset=1 next cycle, load_count=0, in_ready=1.
- Toggle in_valid every other cycle with 10 bytes -> exactly 10 writes, load_count=10, byte order preserved (check with extra=9 read).

Source files
------------

// File: rtl/program_loader.sv
// Streams a bytecode image into local byte storage, holds the CPU in reset until
// the image is complete, then serves bounded little-endian multi-byte CPU fetches.
module program_loader #(
    parameter int AW    = 5,
    parameter int EXTRA = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    input  logic                      reload,
    output logic                      cpu_reset,
    output logic [AW+1:0]             load_count,
    output logic                      load_error,
    input  logic [AW:0]               mem_addr,
    input  logic [EXTRA-1:0]          mem_extra,
    input  logic [AW:0]               lower_bound,
    input  logic [AW:0]               upper_bound,
    output logic [(2**EXTRA)*8-1:0]   mem_data,
    output logic                      mem_error
);
    localparam int DEPTH = 2**(AW+1);
    localparam int LANES = 2**EXTRA;
    localparam int SW    = AW + 2;

    typedef enum logic [1:0] {S_LOAD, S_DONE, S_ERROR} state_t;

    state_t                  r_state;
    logic [AW:0]             r_ptr;
    logic [SW-1:0]           r_count;
    logic                    r_load_error;
    logic                    r_cpu_reset;
    logic                    r_in_ready;
    logic [7:0]              r_mem [DEPTH];
    logic [LANES-1:0][7:0]   r_mem_data;
    logic                    r_mem_error;

    logic                    w_accept;
    logic [SW-1:0]           w_end;
    logic                    w_err;
    logic [LANES-1:0][7:0]   w_data;

    assign w_accept = in_valid && r_in_ready && (r_state == S_LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LOAD;
            r_ptr        <= '0;
            r_count      <= '0;
            r_load_error <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_in_ready   <= 1'b0;
        end else if (reload) begin
            // reload overrides any byte offered in the same cycle
            r_state      <= S_LOAD;
            r_ptr        <= '0;
            r_count      <= '0;
            r_load_error <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_in_ready   <= 1'b1;
        end else begin
            r_cpu_reset <= (r_state != S_DONE);
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_ptr   <= r_ptr + (AW+1)'(1);
                        r_count <= r_count + SW'(1);
                        if (in_last) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                        end else if (r_ptr == (AW+1)'(DEPTH-1)) begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                            r_in_ready   <= 1'b0;
                        end
                    end
                end
                S_DONE:  r_in_ready <= 1'b0;
                default: r_in_ready <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !reload)
            r_mem[r_ptr] <= in_data;
    end

    // end address is one bit wider than the address so it can't wrap
    assign w_end = SW'(mem_addr) + SW'(mem_extra);
    assign w_err = (r_state != S_DONE)
                || (mem_addr < lower_bound)
                || (w_end > SW'(upper_bound))
                || (w_end > SW'(DEPTH-1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [AW:0] w_idx;
        assign w_idx     = mem_addr + (AW+1)'(g);
        assign w_data[g] = (EXTRA'(g) <= mem_extra) ? r_mem[w_idx] : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_data  <= '0;
            r_mem_error <= 1'b1;
        end else begin
            r_mem_data  <= w_err ? '0 : w_data;
            r_mem_error <= w_err;
        end
    end

    assign in_ready   = r_in_ready;
    assign cpu_reset  = r_cpu_reset;
    assign load_count = r_count;
    assign load_error = r_load_error;
    assign mem_data   = r_mem_data;
    assign mem_error  = r_mem_error;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, async reset, overflow, reload and read port bounds.
module tb_program_loader;
    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         reload;
    logic         cpu_reset;
    logic [6:0]   load_count;
    logic         load_error;
    logic [5:0]   mem_addr;
    logic [3:0]   mem_extra;
    logic [5:0]   lower_bound;
    logic [5:0]   upper_bound;
    logic [127:0] mem_data;
    logic         mem_error;

    int checks   = 0;
    int failures = 0;

    program_loader #(.AW(5), .EXTRA(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .reload(reload), .cpu_reset(cpu_reset),
        .load_count(load_count), .load_error(load_error), .mem_addr(mem_addr),
        .mem_extra(mem_extra), .lower_bound(lower_bound), .upper_bound(upper_bound),
        .mem_data(mem_data), .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [3:0] x);
        mem_addr = a; mem_extra = x;
        @(negedge clk);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic send_hello();
        send(8'h41, 1'b0); send(8'h03, 1'b0); send(8'h0B, 1'b0);
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; reload = 1'b0;
        mem_addr = '0; mem_extra = '0; lower_bound = 6'd0; upper_bound = 6'd63;

        @(negedge clk);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_count", load_count, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_mem_error", mem_error, 1);
        chk("rst_mem_data", mem_data, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // basic 6-byte image
        send_hello();
        chk("t1_ready_low", in_ready, 0);
        chk("t1_count", load_count, 6);
        chk("t1_cpu_reset_still", cpu_reset, 1);
        @(negedge clk);
        chk("t1_cpu_reset_fall", cpu_reset, 0);
        rd(6'd0, 4'd1);
        chk("t1_rd_data", mem_data, 128'h0341);
        chk("t1_rd_err", mem_error, 0);

        // reload while DONE, then read during LOAD
        pulse_reload();
        chk("rl_cpu_reset", cpu_reset, 1);
        chk("rl_count", load_count, 0);
        chk("rl_in_ready", in_ready, 1);
        mem_extra = 4'd0;
        @(negedge clk);
        chk("load_rd_err", mem_error, 1);
        chk("load_rd_data", mem_data, 0);

        // asynchronous reset mid-load
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
        chk("mid_count", load_count, 3);
        reset = 1'b0;
        #1;
        chk("arst_cpu_reset", cpu_reset, 1);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_count", load_count, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", in_ready, 1);
        send_hello();
        chk("arst_restream_count", load_count, 6);
        @(negedge clk);
        chk("arst_restream_cpu", cpu_reset, 0);
        rd(6'd0, 4'd1);
        chk("arst_restream_rd", mem_data, 128'h0341);

        // full-depth image, last on byte 64
        pulse_reload();
        for (int i = 0; i < 64; i++) send(8'(i * 3 + 1), (i == 63));
        chk("full_ready_low", in_ready, 0);
        chk("full_count", load_count, 64);
        chk("full_load_error", load_error, 0);
        @(negedge clk);
        chk("full_cpu_reset", cpu_reset, 0);
        rd(6'd62, 4'd1);
        chk("rd62_data", mem_data, 128'hBEBB);
        chk("rd62_err", mem_error, 0);
        rd(6'd63, 4'd1);
        chk("rd63_err", mem_error, 1);
        chk("rd63_data", mem_data, 0);
        lower_bound = 6'd8;
        rd(6'd4, 4'd0);
        chk("rd_lower_err", mem_error, 1);
        upper_bound = 6'd10;
        rd(6'd8, 4'd2);
        chk("rd_upper_ok_data", mem_data, 128'h1F1C19);
        chk("rd_upper_ok_err", mem_error, 0);
        rd(6'd8, 4'd3);
        chk("rd_upper_err", mem_error, 1);
        lower_bound = 6'd0; upper_bound = 6'd63;

        // reload coincident with a valid byte discards the byte
        pulse_reload();
        send(8'h01, 1'b0); send(8'h02, 1'b0);
        chk("coin_pre_count", load_count, 2);
        in_valid = 1'b1; in_data = 8'h03;
        pulse_reload();
        in_valid = 1'b0;
        chk("coin_count", load_count, 0);
        chk("coin_ready", in_ready, 1);

        // overflow: 64 bytes without last, then a 65th
        for (int i = 0; i < 64; i++) send(8'(i + 100), 1'b0);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_load_error", load_error, 1);
        chk("ovf_count", load_count, 64);
        send(8'hEE, 1'b0);
        chk("ovf_65_count", load_count, 64);
        chk("ovf_cpu_reset", cpu_reset, 1);
        rd(6'd0, 4'd0);
        chk("ovf_rd_err", mem_error, 1);

        // throttled stream: valid every other cycle
        pulse_reload();
        chk("thr_err_clear", load_error, 0);
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h10 + i), (i == 9));
            @(negedge clk);
            if (i == 4) chk("thr_mid_count", load_count, 5);
        end
        chk("thr_count", load_count, 10);
        chk("thr_cpu_reset", cpu_reset, 0);
        rd(6'd0, 4'd9);
        chk("thr_rd_data", mem_data, 128'h19181716151413121110);
        chk("thr_rd_err", mem_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
